// File: rtl/ws2812_column_scheduler_if.sv
// Signal bundle between the column scheduler, the frame RAM and the ws2812 driver.
// The brightness input exists only when BRIGHTNESS_SCALE_EN is defined.
`timescale 1ns/1ps
interface ws2812_column_scheduler_if #(
    parameter int unsigned LED_COUNT  = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned COL_WIDTH  = 5
);
    logic                      enable;
    logic                      col_tick;
    logic                      index_pulse;
    logic [ADDR_WIDTH-1:0]     ram_addr;
    logic [23:0]               ram_data;
    logic [LED_COUNT*24-1:0]   drv_data;
    logic                      drv_start;
    logic                      drv_busy;
    logic [COL_WIDTH-1:0]      column;
    logic                      col_done;
    logic                      overrun;
`ifdef BRIGHTNESS_SCALE_EN
    logic [7:0]                brightness;

    modport master (
        input  enable, col_tick, index_pulse, ram_data, drv_busy, brightness,
        output ram_addr, drv_data, drv_start, column, col_done, overrun
    );
    modport slave (
        output enable, col_tick, index_pulse, ram_data, drv_busy, brightness,
        input  ram_addr, drv_data, drv_start, column, col_done, overrun
    );
`else
    modport master (
        input  enable, col_tick, index_pulse, ram_data, drv_busy,
        output ram_addr, drv_data, drv_start, column, col_done, overrun
    );
    modport slave (
        output enable, col_tick, index_pulse, ram_data, drv_busy,
        input  ram_addr, drv_data, drv_start, column, col_done, overrun
    );
`endif
endinterface

// File: rtl/ws2812_column_scheduler.sv
// Column sequencer for a POV display: fetch one column of pixels, hand it to the ws2812 driver.
// Optional per-pixel brightness scaling at capture is enabled by defining BRIGHTNESS_SCALE_EN.
`timescale 1ns/1ps
module ws2812_column_scheduler #(
    parameter int unsigned LED_COUNT  = 8,
    parameter int unsigned COLUMNS    = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned COL_WIDTH  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    ws2812_column_scheduler_if.master bus
);
    localparam int unsigned KW = $clog2(LED_COUNT + 1);
    localparam int unsigned DW = LED_COUNT * 24;
    localparam logic [KW-1:0]        KLast   = KW'(LED_COUNT);
    localparam logic [COL_WIDTH-1:0] ColLast = COL_WIDTH'(COLUMNS - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StArm, StSend} state_e;

    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [KW-1:0]        k_addr;
    logic [COL_WIDTH-1:0] column_q, column_d;
    logic [COL_WIDTH-1:0] fetch_col_q, fetch_col_d;
    logic                 pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic [DW-1:0]        shadow_q, shadow_d;
    logic [DW-1:0]        drv_data_q, drv_data_d;
    logic [23:0]          pixel;
    logic                 fetch_entry;
    logic                 drv_start;
    logic                 col_done;

`ifdef BRIGHTNESS_SCALE_EN
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
        return 8'((16'(c) * (16'(b) + 16'd1)) >> 8);
    endfunction

    assign pixel = {scale_chan(bus.ram_data[23:16], bus.brightness),
                    scale_chan(bus.ram_data[15:8],  bus.brightness),
                    scale_chan(bus.ram_data[7:0],   bus.brightness)};
`else
    assign pixel = bus.ram_data;
`endif

    // k runs one past the last LED to catch the final sync-read word; hold the address there.
    assign k_addr       = (k_q == KLast) ? KW'(LED_COUNT - 1) : k_q;
    assign bus.ram_addr = ADDR_WIDTH'(fetch_col_q) * ADDR_WIDTH'(LED_COUNT)
                        + ADDR_WIDTH'(k_addr);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        column_d    = column_q;
        fetch_col_d = fetch_col_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        shadow_d    = shadow_q;
        drv_data_d  = drv_data_q;
        fetch_entry = 1'b0;
        drv_start   = 1'b0;
        col_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pending_q && bus.enable) begin
                    fetch_entry = 1'b1;
                    k_d         = '0;
                    fetch_col_d = bus.index_pulse ? '0 : column_q;
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                for (int i = 0; i < int'(LED_COUNT); i++) begin
                    if (k_q == KW'(i + 1)) shadow_d[i*24 +: 24] = pixel;
                end
                if (k_q == KLast) begin
                    // Publish on the LOAD boundary so data is valid alongside drv_start.
                    drv_data_d = shadow_d;
                    state_d    = StLoad;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StLoad: begin
                drv_start = 1'b1;
                state_d   = StArm;
            end
            StArm: begin
                state_d = StSend;
            end
            StSend: begin
                if (!bus.drv_busy) begin
                    col_done = 1'b1;
                    column_d = (column_q == ColLast) ? '0 : column_q + COL_WIDTH'(1);
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (fetch_entry) pending_d = 1'b0;
        // A tick landing on the fetch-entry edge queues the next column instead of overrunning.
        if (bus.col_tick) begin
            if (pending_q && !fetch_entry) overrun_d = 1'b1;
            pending_d = 1'b1;
        end
        if (bus.index_pulse) column_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            column_q    <= '0;
            fetch_col_q <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            shadow_q    <= '0;
            drv_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            column_q    <= column_d;
            fetch_col_q <= fetch_col_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            shadow_q    <= shadow_d;
            drv_data_q  <= drv_data_d;
        end
    end

    assign bus.drv_data  = drv_data_q;
    assign bus.drv_start = drv_start;
    assign bus.column    = column_q;
    assign bus.col_done  = col_done;
    assign bus.overrun   = overrun_q;

endmodule
